// File: rtl/traffic_monitor.sv
// Passive checker for the intersection lights bus: decodes the active
// phase, checks phase order and dwell, and counts errors and cycles.
module traffic_monitor #(
   parameter int LONG_CYC  = 16,
   parameter int SHORT_CYC = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [5:0] lights,
   output logic [2:0] phase,
   output logic       phase_valid,
   output logic       locked,
   output logic [3:0] err_flags,
   output logic [7:0] err_count,
   output logic [7:0] cycle_count
);

   localparam logic [5:0] P0 = 6'b100001;
   localparam logic [5:0] P1 = 6'b100010;
   localparam logic [5:0] P2 = 6'b100100;
   localparam logic [5:0] P3 = 6'b001100;
   localparam logic [5:0] P4 = 6'b010100;
   localparam logic [5:0] P5 = 6'b100100;

   localparam logic [7:0] LONG_LEN  = 8'(LONG_CYC);
   localparam logic [7:0] SHORT_LEN = 8'(SHORT_CYC);

   typedef enum logic {
      ACQUIRE,
      TRACK
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cur_q, cur_d;
   logic [7:0] dwell_q, dwell_d;
   logic       ovr_q, ovr_d;
   logic [5:0] prev_q, prev_d;
   logic [3:0] flags_q, flags_d;
   logic [7:0] errc_q, errc_d;
   logic [7:0] cyc_q, cyc_d;

   logic [2:0] nxt;
   logic [5:0] cur_pat;
   logic [5:0] nxt_pat;
   logic [7:0] req;
   logic       legal;
   logic       conflict;
   logic       e_conf;
   logic       e_pat;
   logic       e_seq;
   logic       e_tim;

   function automatic logic [5:0] pat_of(input logic [2:0] p);
      logic [5:0] r;
      r = P0;
      case (p)
         3'd0:    r = P0;
         3'd1:    r = P1;
         3'd2:    r = P2;
         3'd3:    r = P3;
         3'd4:    r = P4;
         3'd5:    r = P5;
         default: r = P0;
      endcase
      return r;
   endfunction

   always_comb begin
      nxt      = (cur_q == 3'd5) ? 3'd0 : cur_q + 3'd1;
      cur_pat  = pat_of(cur_q);
      nxt_pat  = pat_of(nxt);
      req      = (cur_q == 3'd0 || cur_q == 3'd3) ? LONG_LEN : SHORT_LEN;
      legal    = (lights == P0) || (lights == P1) || (lights == P2) ||
                 (lights == P3) || (lights == P4);
      conflict = !lights[5] && !lights[2];
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      dwell_d = dwell_q;
      ovr_d   = ovr_q;
      prev_d  = lights;
      cyc_d   = cyc_q;
      e_conf  = 1'b0;
      e_pat   = 1'b0;
      e_seq   = 1'b0;
      e_tim   = 1'b0;

      case (state_q)
         ACQUIRE: begin
            // Lock only on the rising edge of P0, never mid-phase
            if (lights == P0 && prev_q != P0) begin
               state_d = TRACK;
               cur_d   = 3'd0;
               dwell_d = 8'd1;
               ovr_d   = 1'b0;
            end
         end
         TRACK: begin
            if (conflict || !legal) begin
               e_conf  = conflict;
               e_pat   = 1'b1;
               state_d = ACQUIRE;
            end else if (lights == cur_pat) begin
               if (dwell_q >= req && !ovr_q) begin
                  e_tim = 1'b1;
                  ovr_d = 1'b1;
               end
               if (dwell_q != 8'd255)
                  dwell_d = dwell_q + 8'd1;
            end else if (lights == nxt_pat) begin
               // An overstay already reported this visit is not repeated
               if (dwell_q != req && !ovr_q)
                  e_tim = 1'b1;
               cur_d   = nxt;
               dwell_d = 8'd1;
               ovr_d   = 1'b0;
               if (cur_q == 3'd5)
                  cyc_d = cyc_q + 8'd1;
            end else begin
               e_seq   = 1'b1;
               state_d = ACQUIRE;
            end
            if (state_d == ACQUIRE) begin
               cur_d   = 3'd0;
               dwell_d = 8'd0;
               ovr_d   = 1'b0;
            end
         end
         default: state_d = ACQUIRE;
      endcase

      flags_d = flags_q | {e_tim, e_seq, e_pat, e_conf};
      errc_d  = errc_q;
      if ((e_tim || e_seq || e_pat || e_conf) && errc_q != 8'd255)
         errc_d = errc_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ACQUIRE;
         cur_q   <= 3'd0;
         dwell_q <= 8'd0;
         ovr_q   <= 1'b0;
         prev_q  <= 6'd0;
         flags_q <= 4'd0;
         errc_q  <= 8'd0;
         cyc_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         dwell_q <= dwell_d;
         ovr_q   <= ovr_d;
         prev_q  <= prev_d;
         flags_q <= flags_d;
         errc_q  <= errc_d;
         cyc_q   <= cyc_d;
      end
   end

   assign phase       = cur_q;
   assign locked      = (state_q == TRACK);
   assign phase_valid = (state_q == TRACK);
   assign err_flags   = flags_q;
   assign err_count   = errc_q;
   assign cycle_count = cyc_q;

endmodule
